// File: rtl/rega_display_scan.sv
// Irrigation mode FSM with BCD cycle timers, driving a multiplexed active-low
// 7-segment panel: digit 0 shows a mode glyph, the rest show the remaining time.
module rega_display_scan #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int T_ASP    = 30,
    parameter int T_GOT    = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Bs,
    input  logic              Vs,
    input  logic              ERRO,
    input  logic              Ve,
    output logic [6:0]        SEGs,
    output logic              SEG_P,
    output logic [DIGITS-1:0] SEG_D,
    output logic              Busy,
    output logic              Done
);

    function automatic int maxTime(input int d);
        int r;
        r = 1;
        for (int i = 0; i < d - 1; i++) r = r * 10;
        return r - 1;
    endfunction

    function automatic logic [31:0] toBcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    generate
        if (DIGITS < 2 || DIGITS > 8 || T_ASP > maxTime(DIGITS) || T_GOT > maxTime(DIGITS)
            || TICK_DIV < 1 || SCAN_DIV < 1) begin : gBadParams
            $error("rega_display_scan: DIGITS out of range or cycle length does not fit the time field");
        end
    endgenerate

    localparam int TW    = 4 * (DIGITS - 1);
    localparam int IDXW  = $clog2(DIGITS);
    localparam int TICKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCANW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TW-1:0] ASP_BCD = TW'(toBcd(T_ASP));
    localparam logic [TW-1:0] GOT_BCD = TW'(toBcd(T_GOT));

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ASP  = 2'd1;
    localparam logic [1:0] GOT  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_G     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_O     = 7'b0100011;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] bcdGlyph(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timerDec;
    logic [TICKW-1:0] tickPresc;
    logic [SCANW-1:0] scanPresc;
    logic [IDXW-1:0]  scanIdx;
    logic             bsPrev;
    logic             vsPrev;
    logic             doneFlag;
    logic             bsRise;
    logic             vsRise;
    logic             tickHit;
    logic             scanHit;
    logic             running;
    logic [3:0]       curNibble;
    logic [6:0]       curGlyph;
    logic [DIGITS-1:0] digitSel;

    assign bsRise  = Bs & ~bsPrev;
    assign vsRise  = Vs & ~vsPrev;
    assign running = (state == ASP) || (state == GOT);
    assign tickHit = running && (tickPresc == TICKW'(TICK_DIV - 1));
    assign scanHit = (scanPresc == SCANW'(SCAN_DIV - 1));
    assign SEG_P   = 1'b1;

    // Decimal down-count: a zero digit becomes 9 and passes the borrow upward.
    always_comb begin
        logic borrow;
        timerDec = timer;
        borrow   = 1'b1;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (borrow) begin
                if (timer[4*i +: 4] == 4'd0) begin
                    timerDec[4*i +: 4] = 4'd9;
                end else begin
                    timerDec[4*i +: 4] = timer[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            timer     <= '0;
            tickPresc <= '0;
            bsPrev    <= 1'b0;
            vsPrev    <= 1'b0;
            doneFlag  <= 1'b0;
        end else begin
            bsPrev   <= Bs;
            vsPrev   <= Vs;
            doneFlag <= 1'b0;
            if (ERRO) begin
                state     <= ERR;
                tickPresc <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tickPresc <= '0;
                        if (bsRise) begin
                            state <= ASP;
                            timer <= ASP_BCD;
                        end else if (vsRise) begin
                            state <= GOT;
                            timer <= GOT_BCD;
                        end
                    end
                    ASP, GOT: begin
                        if (tickHit) begin
                            tickPresc <= '0;
                            if (timer <= TW'(1)) begin
                                timer    <= '0;
                                state    <= IDLE;
                                doneFlag <= 1'b1;
                            end else begin
                                timer <= timerDec;
                            end
                        end else begin
                            tickPresc <= tickPresc + TICKW'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        timer     <= '0;
                        tickPresc <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            scanPresc <= '0;
            scanIdx   <= '0;
        end else if (scanHit) begin
            scanPresc <= '0;
            scanIdx   <= (scanIdx == IDXW'(DIGITS - 1)) ? '0 : scanIdx + IDXW'(1);
        end else begin
            scanPresc <= scanPresc + SCANW'(1);
        end
    end

    // Digit 1 is the most significant time digit.
    always_comb begin
        curNibble = 4'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (scanIdx == IDXW'(i)) curNibble = timer[4*(DIGITS-1-i) +: 4];
        end
    end

    always_comb begin
        curGlyph = GLYPH_BLANK;
        case (state)
            IDLE: if (scanIdx == '0) curGlyph = Ve ? GLYPH_O : GLYPH_DASH;
            ASP:  curGlyph = (scanIdx == '0) ? GLYPH_A : bcdGlyph(curNibble);
            GOT:  curGlyph = (scanIdx == '0) ? GLYPH_G : bcdGlyph(curNibble);
            default: curGlyph = (scanIdx == '0) ? GLYPH_E : GLYPH_R;
        endcase
        digitSel = ~(DIGITS'(1) << scanIdx);
    end

    // The first cycle of every slot keeps all digits off to avoid ghosting.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            SEGs  <= GLYPH_BLANK;
            SEG_D <= '1;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            SEGs  <= curGlyph;
            SEG_D <= (scanPresc == '0) ? '1 : digitSel;
            Busy  <= running;
            Done  <= doneFlag;
        end
    end

endmodule

// File: tb/tb_rega_display_scan.sv
// Directed bench for rega_display_scan: scan order, sprinkler and drip runs,
// simultaneous requests, fault handling and asynchronous reset.
module tb_rega_display_scan;

    logic       Clk;
    logic       Rst;
    logic       Bs;
    logic       Vs;
    logic       ERRO;
    logic       Ve;
    logic [6:0] SEGs;
    logic       SEG_P;
    logic [3:0] SEG_D;
    logic       Busy;
    logic       Done;

    int total;
    int bad;
    int edgeN;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GG = 7'b1000010;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GR = 7'b0101111;
    localparam logic [6:0] GO = 7'b0100011;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GB = 7'b1111111;

    rega_display_scan #(
        .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .T_ASP(12), .T_GOT(3)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Bs(Bs), .Vs(Vs), .ERRO(ERRO), .Ve(Ve),
        .SEGs(SEGs), .SEG_P(SEG_P), .SEG_D(SEG_D), .Busy(Busy), .Done(Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic bs, input logic vs, input logic erro, input logic ve);
        Bs   = bs;
        Vs   = vs;
        ERRO = erro;
        Ve   = ve;
    endtask

    task automatic advanceTo(input int n);
        while (edgeN < n) begin
            @(posedge Clk);
            #1;
            edgeN++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expSeg, input logic [3:0] expDig,
                               input logic expBusy, input logic expDone);
        total++;
        assert (SEGs === expSeg && SEG_D === expDig && Busy === expBusy && Done === expDone
                && SEG_P === 1'b1)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed seg=%b dig=%b busy=%b done=%b p=%b expected seg=%b dig=%b busy=%b done=%b p=1",
                   tag, SEGs, SEG_D, Busy, Done, SEG_P, expSeg, expDig, expBusy, expDone);
        end
    endtask

    task automatic checkFlags(input string tag, input logic expBusy, input logic expDone);
        total++;
        assert (Busy === expBusy && Done === expDone)
        else begin
            bad++;
            $error("[TB] FAIL %s @edge %0d: observed busy=%b done=%b expected busy=%b done=%b",
                   tag, edgeN, Busy, Done, expBusy, expDone);
        end
    endtask

    // Reset held for three clocks, released just after a rising edge.
    task automatic doReset();
        Rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_hold", GB, 4'hF, 1'b0, 1'b0);
        Rst   = 1'b1;
        edgeN = 0;
    endtask

    initial begin
        logic [3:0] scanDig [8];
        logic [6:0] scanSeg [8];
        total = 0;
        bad   = 0;
        edgeN = 0;
        Rst   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        scanDig = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
        scanSeg = '{GO, GO, GB, GB, GB, GB, GB, GB};
        doReset();
        for (int i = 0; i < 8; i++) begin
            advanceTo(i + 1);
            checkOutput($sformatf("scan_slot%0d", i), scanSeg[i], scanDig[i], 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        advanceTo(9);  checkOutput("scan_dash_blank", GD, 4'hF, 1'b0, 1'b0);
        advanceTo(10); checkOutput("scan_dash_on",    GD, 4'hE, 1'b0, 1'b0);
        advanceTo(11); checkOutput("scan_dash_next",  GB, 4'hF, 1'b0, 1'b0);

        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        advanceTo(1);  checkOutput("asp_entry_lag", GO, 4'hF, 1'b0, 1'b0);
        advanceTo(2);  checkOutput("asp_glyph_A",   GA, 4'hE, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        advanceTo(4);  checkOutput("asp_012_d1",    G0, 4'hD, 1'b1, 1'b0);
        advanceTo(5);  checkOutput("asp_012_d2",    G1, 4'hF, 1'b1, 1'b0);
        advanceTo(6);  checkOutput("asp_011_d2",    G1, 4'hB, 1'b1, 1'b0);
        advanceTo(7);  checkOutput("asp_011_d3a",   G1, 4'hF, 1'b1, 1'b0);
        advanceTo(8);  checkOutput("asp_011_d3b",   G1, 4'h7, 1'b1, 1'b0);
        advanceTo(10); checkOutput("asp_glyph_A2",  GA, 4'hE, 1'b1, 1'b0);
        advanceTo(12); checkOutput("asp_010_d1",    G0, 4'hD, 1'b1, 1'b0);
        advanceTo(14); checkOutput("asp_009_d2",    G0, 4'hB, 1'b1, 1'b0);
        advanceTo(15); checkOutput("asp_009_d3a",   G9, 4'hF, 1'b1, 1'b0);
        advanceTo(16); checkOutput("asp_009_d3b",   G9, 4'h7, 1'b1, 1'b0);
        advanceTo(49); checkOutput("asp_last_tick", GA, 4'hF, 1'b1, 1'b0);
        advanceTo(50); checkOutput("asp_done",      GO, 4'hE, 1'b0, 1'b1);
        advanceTo(51); checkOutput("asp_done_end",  GB, 4'hF, 1'b0, 1'b0);

        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        advanceTo(6);  checkOutput("rst_pre_busy",  G1, 4'hB, 1'b1, 1'b0);
        Rst = 1'b0;
        #2;
        checkOutput("rst_async", GB, 4'hF, 1'b0, 1'b0);

        doReset();
        advanceTo(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        advanceTo(4);  checkOutput("sim_pre",       GB, 4'hD, 1'b0, 1'b0);
        advanceTo(5);  checkOutput("sim_012_d2",    G1, 4'hF, 1'b1, 1'b0);
        advanceTo(7);  checkOutput("sim_012_d3a",   G2, 4'hF, 1'b1, 1'b0);
        advanceTo(8);  checkOutput("sim_012_d3b",   G2, 4'h7, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        advanceTo(9);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        advanceTo(10); checkOutput("sim_glyph_A",   GA, 4'hE, 1'b1, 1'b0);
        advanceTo(12); checkOutput("sim_011_d1",    G0, 4'hD, 1'b1, 1'b0);
        advanceTo(14); checkOutput("sim_010_d2",    G1, 4'hB, 1'b1, 1'b0);
        advanceTo(16); checkOutput("sim_010_d3",    G0, 4'h7, 1'b1, 1'b0);

        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        advanceTo(6);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        advanceTo(7);  checkOutput("err_pre",       G2, 4'hF, 1'b1, 1'b0);
        advanceTo(8);  checkOutput("err_r_d3",      GR, 4'h7, 1'b0, 1'b0);
        advanceTo(10); checkOutput("err_E_d0",      GE, 4'hE, 1'b0, 1'b0);
        advanceTo(12); checkOutput("err_r_d1",      GR, 4'hD, 1'b0, 1'b0);
        for (int n = 13; n <= 20; n++) begin
            advanceTo(n);
            checkFlags("err_hold", 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        advanceTo(21); checkOutput("err_last",      GR, 4'hF, 1'b0, 1'b0);
        advanceTo(22); checkOutput("err_to_idle",   GB, 4'hB, 1'b0, 1'b0);
        advanceTo(25); checkOutput("err_idle_o",    GO, 4'hF, 1'b0, 1'b0);
        for (int n = 26; n <= 30; n++) begin
            advanceTo(n);
            checkFlags("err_no_done", 1'b0, 1'b0);
        end

        doReset();
        advanceTo(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        advanceTo(3);  checkOutput("got_pre",       GB, 4'hF, 1'b0, 1'b0);
        advanceTo(4);  checkOutput("got_003_d1",    G0, 4'hD, 1'b1, 1'b0);
        advanceTo(7);  checkOutput("got_003_d3",    G3, 4'hF, 1'b1, 1'b0);
        advanceTo(8);  checkOutput("got_002_d3",    G2, 4'h7, 1'b1, 1'b0);
        advanceTo(10); checkOutput("got_glyph_G",   GG, 4'hE, 1'b1, 1'b0);
        advanceTo(12); checkOutput("got_001_d1",    G0, 4'hD, 1'b1, 1'b0);
        advanceTo(14); checkOutput("got_001_d2",    G0, 4'hB, 1'b1, 1'b0);
        advanceTo(15); checkOutput("got_001_d3",    G1, 4'hF, 1'b1, 1'b0);
        advanceTo(16); checkOutput("got_done",      GB, 4'h7, 1'b0, 1'b1);
        advanceTo(17); checkOutput("got_done_end",  GO, 4'hF, 1'b0, 1'b0);
        for (int n = 18; n <= 26; n++) begin
            advanceTo(n);
            checkFlags("got_no_wrap", 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
